hc_add_scheduler: RTL and testbench

Multi-precision add controller that shares one 8-bit Han-Carlson prefix adder (HCadd8) between two requesters. It accepts a WORDS×8-bit add from requester 0 or 1 under round-robin arbitration. It then drives the shared adder one byte slice per cycle, least significant slice first, and chains the carry between slices through a register. The result is returned on a valid/ready response channel tagged with the requester ID. The block instantiates the single HCadd8 internally and is its only user.

---
 rtl/hc_add_scheduler.sv | 160 ++++++++++++++++
 tb/tb_hc_add_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hc_add_scheduler.sv
// rtl/hc_add_scheduler.sv - two-requester multi-precision add controller over one shared HCadd8
// Operands are walked one byte slice per cycle, LSB first, carry chained through carry_reg.

module hcadd8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] g, p;
    logic g0c, g1_1, g1_3, p1_3, g1_5, p1_5, g1_7, p1_7;
    logic g2_5, p2_5, g2_7, p2_7;
    logic c2, c3, c4, c5, c6, c7;

    assign g = a & b;
    assign p = a ^ b;
    // cin is folded into bit 0 so every prefix group below spans down to the carry-in
    assign g0c  = g[0] | (p[0] & cin);

    // Han-Carlson: Kogge-Stone tree on odd bits, then one extra level fixes up even bits
    assign g1_1 = g[1] | (p[1] & g0c);
    assign g1_3 = g[3] | (p[3] & g[2]);
    assign p1_3 = p[3] & p[2];
    assign g1_5 = g[5] | (p[5] & g[4]);
    assign p1_5 = p[5] & p[4];
    assign g1_7 = g[7] | (p[7] & g[6]);
    assign p1_7 = p[7] & p[6];

    assign c3   = g1_3 | (p1_3 & g1_1);
    assign g2_5 = g1_5 | (p1_5 & g1_3);
    assign p2_5 = p1_5 & p1_3;
    assign g2_7 = g1_7 | (p1_7 & g1_5);
    assign p2_7 = p1_7 & p1_5;

    assign c5   = g2_5 | (p2_5 & g1_1);
    assign c7   = g2_7 | (p2_7 & c3);

    assign c2   = g[2] | (p[2] & g1_1);
    assign c4   = g[4] | (p[4] & c3);
    assign c6   = g[6] | (p[6] & c5);

    assign s    = p ^ {c6, c5, c4, c3, c2, g1_1, g0c, cin};
    assign cout = c7;
endmodule

module hc_add_scheduler #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [8*WORDS-1:0]   req0_a,
    input  logic [8*WORDS-1:0]   req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [8*WORDS-1:0]   req1_a,
    input  logic [8*WORDS-1:0]   req1_b,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8*WORDS-1:0]   rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_id,
    output logic                 busy
);
    localparam int W  = 8 * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [KW-1:0]  k;
    logic           ptr;
    logic [W-1:0]   a_lat, b_lat, sum_reg;
    logic           cin_lat, carry_reg, id_lat;
    logic           grant0, grant1, accept, last_slice;
    logic [7:0]     a_sl, b_sl, s_sl;
    logic           c_in_sl, c_out_sl;

    // ptr=0 favours req0, ptr=1 favours req1
    assign grant0     = req0_valid & (~req1_valid | ~ptr);
    assign grant1     = req1_valid & (~req0_valid | ptr);
    assign accept     = (state == IDLE) & (grant0 | grant1);
    assign last_slice = (k == KW'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = rst_n & (state == IDLE) & grant0;
        req1_ready = rst_n & (state == IDLE) & grant1;
        rsp_valid  = (state == DONE);
        busy       = (state == RUN) | (state == DONE);
    end

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k == KW'(i)) begin
                a_sl = a_lat[8*i +: 8];
                b_sl = b_lat[8*i +: 8];
            end
        end
        c_in_sl = (k == '0) ? cin_lat : carry_reg;
    end

    hcadd8 u_hcadd8 (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (c_in_sl),
        .s    (s_sl),
        .cout (c_out_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            ptr       <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
            cin_lat   <= 1'b0;
            id_lat    <= 1'b0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (accept) begin
            a_lat   <= grant1 ? req1_a : req0_a;
            b_lat   <= grant1 ? req1_b : req0_b;
            cin_lat <= grant1 ? req1_cin : req0_cin;
            id_lat  <= grant1;
            ptr     <= ~grant1;
            k       <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (k == KW'(i)) sum_reg[8*i +: 8] <= s_sl;
            end
            carry_reg <= c_out_sl;
            k         <= k + 1'b1;
        end
    end

    assign rsp_sum  = sum_reg;
    assign rsp_cout = carry_reg;
    assign rsp_id   = id_lat;
endmodule

// File: tb/tb_hc_add_scheduler.sv
// tb/tb_hc_add_scheduler.sv - directed self-checking bench for hc_add_scheduler (WORDS=4 and WORDS=1)

module tb_hc_add_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        r0v, r0r, r0c, r1v, r1r, r1c, rv, rr, rcout, rid, busy;
    logic [31:0] r0a, r0b, r1a, r1b, rsum;
    logic        q0v, q0r, q0c, q1v, q1r, q1c, qv, qr, qcout, qid, qbusy;
    logic [7:0]  q0a, q0b, q1a, q1b, qsum;

    int checks = 0;
    int failures = 0;

    hc_add_scheduler #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_sum(rsum), .rsp_cout(rcout), .rsp_id(rid),
        .busy(busy)
    );

    hc_add_scheduler #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(q0v), .req0_ready(q0r), .req0_a(q0a), .req0_b(q0b), .req0_cin(q0c),
        .req1_valid(q1v), .req1_ready(q1r), .req1_a(q1a), .req1_b(q1b), .req1_cin(q1c),
        .rsp_valid(qv), .rsp_ready(qr), .rsp_sum(qsum), .rsp_cout(qcout), .rsp_id(qid),
        .busy(qbusy)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one op on dut4, returns the response and cycles from handshake to first rsp_valid
    task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b, input bit cin,
                          output logic [31:0] sum, output logic cout, output logic rid_o,
                          output int lat, output bit ok);
        int n;
        ok = 1'b0; lat = 0; sum = '0; cout = 1'b0; rid_o = 1'b0;
        @(negedge clk);
        if (id) begin r1v = 1'b1; r1a = a; r1b = b; r1c = cin; end
        else    begin r0v = 1'b1; r0a = a; r0b = b; r0c = cin; end
        #1;
        n = 0;
        while (!(id ? r1r : r0r) && n < 20) begin @(negedge clk); #1; n++; end
        if (id ? r1r : r0r) begin
            @(negedge clk);
            r0v = 1'b0; r1v = 1'b0;
            #1;
            lat = 1;
            while (!rv && lat < 50) begin @(negedge clk); #1; lat++; end
            ok = rv; sum = rsum; cout = rcout; rid_o = rid;
        end
        r0v = 1'b0; r1v = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rr = 1'b1; qr = 1'b1;
        r0v = 1'b1; r1v = 1'b1; r0a = '0; r0b = '0; r0c = 1'b0; r1a = '0; r1b = '0; r1c = 1'b0;
        q0v = 1'b0; q1v = 1'b0; q0a = '0; q0b = '0; q0c = 1'b0; q1a = '0; q1b = '0; q1c = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({rv, rcout, rid, busy, r0r, r1r} !== 6'b0)
            begin failures++; $display("FAIL reset_flags got rv=%0b cout=%0b id=%0b busy=%0b r0r=%0b r1r=%0b exp all 0", rv, rcout, rid, busy, r0r, r1r); end
        checks++;
        if (rsum !== 32'h0) begin failures++; $display("FAIL reset_sum got %h exp 00000000", rsum); end
        r0v = 1'b0; r1v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        logic [31:0] s; logic c, d; int lat; bit ok;
        run_op(1'b0, 32'h000000A3, 32'h000000AF, 1'b0, s, c, d, lat, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_rsp got valid=%0b exp 1", ok); end
        checks++; if (s !== 32'h00000152) begin failures++; $display("FAIL single_sum got %h exp 00000152", s); end
        checks++; if ({c, d} !== 2'b00) begin failures++; $display("FAIL single_cout_id got cout=%0b id=%0b exp 0/0", c, d); end
        checks++; if (lat != 5) begin failures++; $display("FAIL single_latency got %0d exp 5", lat); end
    endtask

    task automatic test_carry_ripple();
        logic [31:0] s; logic c, d; int lat; bit ok;
        run_op(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, s, c, d, lat, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ripple_rsp got valid=%0b exp 1", ok); end
        checks++; if (s !== 32'h00000000) begin failures++; $display("FAIL ripple_sum got %h exp 00000000", s); end
        checks++; if ({c, d} !== 2'b11) begin failures++; $display("FAIL ripple_cout_id got cout=%0b id=%0b exp 1/1", c, d); end
    endtask

    task automatic test_round_robin();
        logic        g [3];
        logic [31:0] s [3];
        logic        c [3];
        logic        d [3];
        logic [31:0] exp_s [3];
        logic        exp_g [3];
        logic        exp_c [3];
        int ng, nr, both, cyc;
        exp_s[0] = 32'h23456789; exp_s[1] = 32'h00000000; exp_s[2] = 32'h23456789;
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
        exp_c[0] = 1'b0; exp_c[1] = 1'b1; exp_c[2] = 1'b0;
        apply_reset();
        ng = 0; nr = 0; both = 0; cyc = 0;
        @(negedge clk);
        r0v = 1'b1; r0a = 32'h12345678; r0b = 32'h11111111; r0c = 1'b0;
        r1v = 1'b1; r1a = 32'h80000000; r1b = 32'h80000000; r1c = 1'b0;
        while (cyc < 100) begin
            #1;
            if (r0r && r1r) both++;
            if ((r0r || r1r) && ng < 3) begin g[ng] = r1r; ng++; end
            if (rv && nr < 3) begin s[nr] = rsum; c[nr] = rcout; d[nr] = rid; nr++; end
            if (nr == 3) break;
            @(negedge clk);
            cyc++;
        end
        r0v = 1'b0; r1v = 1'b0;
        @(negedge clk);
        checks++; if (both != 0) begin failures++; $display("FAIL rr_both_ready got %0d cycles exp 0", both); end
        checks++; if (nr != 3 || ng != 3) begin failures++; $display("FAIL rr_count got grants=%0d rsps=%0d exp 3/3", ng, nr); end
        for (int i = 0; i < 3; i++) begin
            if (i < ng) begin
                checks++;
                if (g[i] !== exp_g[i]) begin failures++; $display("FAIL rr_grant%0d got %0b exp %0b", i, g[i], exp_g[i]); end
            end
            if (i < nr) begin
                checks++;
                if (s[i] !== exp_s[i] || c[i] !== exp_c[i] || d[i] !== exp_g[i])
                    begin failures++; $display("FAIL rr_rsp%0d got %h/%0b/%0b exp %h/%0b/%0b", i, s[i], c[i], d[i], exp_s[i], exp_c[i], exp_g[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        rr = 1'b0;
        @(negedge clk);
        r0v = 1'b1; r0a = 32'h01020304; r0b = 32'h10203040; r0c = 1'b1;
        #1;
        checks++; if (r0r !== 1'b1) begin failures++; $display("FAIL bp_accept got %0b exp 1", r0r); end
        @(negedge clk);
        r0v = 1'b0;
        #1;
        n = 0;
        while (!rv && n < 50) begin @(negedge clk); #1; n++; end
        r0v = 1'b1; r1v = 1'b1; r1a = 32'h00000001; r1b = 32'h00000002; r1c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rv !== 1'b1 || rsum !== 32'h11223345 || rcout !== 1'b0 || rid !== 1'b0 ||
                busy !== 1'b1 || r0r !== 1'b0 || r1r !== 1'b0)
                begin failures++; $display("FAIL bp_hold%0d got rv=%0b sum=%h cout=%0b id=%0b busy=%0b rdy=%0b%0b exp 1/11223345/0/0/1/00", i, rv, rsum, rcout, rid, busy, r0r, r1r); end
            @(negedge clk);
        end
        rr = 1'b1;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (rv !== 1'b0 || busy !== 1'b0 || r1r !== 1'b1 || r0r !== 1'b0)
            begin failures++; $display("FAIL bp_release got rv=%0b busy=%0b r0r=%0b r1r=%0b exp 0/0/0/1", rv, busy, r0r, r1r); end
        @(negedge clk);
        r0v = 1'b0; r1v = 1'b0;
        #1;
        n = 0;
        while (!rv && n < 50) begin @(negedge clk); #1; n++; end
        checks++;
        if (rv !== 1'b1 || rsum !== 32'h00000003 || rid !== 1'b1)
            begin failures++; $display("FAIL bp_next_rsp got rv=%0b sum=%h id=%0b exp 1/00000003/1", rv, rsum, rid); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_run();
        logic [31:0] s; logic c, d; int lat; bit ok; int seen;
        @(negedge clk);
        r0v = 1'b1; r0a = 32'h11111111; r0b = 32'h22222222; r0c = 1'b0;
        #1;
        checks++; if (r0r !== 1'b1) begin failures++; $display("FAIL rst_run_accept got %0b exp 1", r0r); end
        @(negedge clk);
        r0v = 1'b0;
        repeat (2) @(negedge clk);
        r1v = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rv, rcout, rid, busy, r0r, r1r} !== 6'b0 || rsum !== 32'h0)
            begin failures++; $display("FAIL rst_run_outputs got rv=%0b sum=%h cout=%0b id=%0b busy=%0b rdy=%0b%0b exp all 0", rv, rsum, rcout, rid, busy, r0r, r1r); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) begin rst_n = 1'b1; r1v = 1'b0; end
            #1;
            if (rv) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_run_no_rsp got %0d exp 0", seen); end
        run_op(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, s, c, d, lat, ok);
        checks++;
        if (ok !== 1'b1 || s !== 32'h00010000 || c !== 1'b0 || d !== 1'b1)
            begin failures++; $display("FAIL rst_run_after got ok=%0b sum=%h cout=%0b id=%0b exp 1/00010000/0/1", ok, s, c, d); end
    endtask

    task automatic test_words1();
        int lat;
        @(negedge clk);
        q0v = 1'b1; q0a = 8'hFF; q0b = 8'h01; q0c = 1'b0;
        #1;
        checks++; if (q0r !== 1'b1) begin failures++; $display("FAIL w1_accept got %0b exp 1", q0r); end
        @(negedge clk);
        q0v = 1'b0;
        #1;
        lat = 1;
        while (!qv && lat < 50) begin @(negedge clk); #1; lat++; end
        checks++; if (lat != 2) begin failures++; $display("FAIL w1_latency got %0d exp 2", lat); end
        checks++;
        if (qv !== 1'b1 || qsum !== 8'h00 || qcout !== 1'b1 || qid !== 1'b0)
            begin failures++; $display("FAIL w1_rsp got v=%0b sum=%h cout=%0b id=%0b exp 1/00/1/0", qv, qsum, qcout, qid); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry_ripple();
        test_round_robin();
        test_backpressure();
        test_reset_in_run();
        test_words1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
